// File: rtl/load_store_unit.sv
// Load/store initiator for a word-wide data memory: sub-word loads by lane
// extraction and sign/zero extension, sub-word stores by read-modify-write.
module load_store_unit #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_input,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_data_out,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and resp_valid is a single-cycle completion
    // pulse that needs no acknowledge.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;

    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [1:0]  lat_lane;
    logic [15:0] lat_wdata;
    logic        lat_err;
    logic [31:0] rdata_q;

    logic        accept;
    logic        req_misaligned;
    logic        rd_done;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    // Size 2'b11 is handled exactly like a word, so size[1] alone means "word".
    assign req_misaligned = (req_size == 2'b01 && req_addr[0]) ||
                            (req_size[1] && req_addr[1:0] != 2'b00);
    assign accept  = req_valid && (state == IDLE);
    assign rd_done = (state == RD) && (cnt == 4'd0);

    assign dbg_state = state;

    function automatic logic [31:0] merge_lane(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic [15:0] wdata
    );
        logic [31:0] merged;
        merged = word;
        if (size == 2'b00) begin
            merged[{lane, 3'b000} +: 8] = wdata[7:0];
        end else if (size == 2'b01) begin
            merged[{lane[1], 4'b0000} +: 16] = wdata;
        end
        return merged;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Strobes decode straight from the state register so an async reset
    // drops mem_write in the same instant.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_misaligned) begin
                        state_next = RESP;
                    end else if (req_write && req_size[1]) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            RD: begin
                mem_read = 1'b1;
                if (cnt == 4'd0) begin
                    state_next = lat_write ? WR : RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            WR: begin
                mem_write  = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_write      <= 1'b0;
            lat_size       <= 2'b00;
            lat_unsigned   <= 1'b0;
            lat_lane       <= 2'b00;
            lat_wdata      <= 16'd0;
            lat_err        <= 1'b0;
            rdata_q        <= 32'd0;
            mem_address    <= 32'd0;
            mem_data_input <= 32'd0;
        end else begin
            if (accept) begin
                lat_write    <= req_write;
                lat_size     <= req_size;
                lat_unsigned <= req_unsigned;
                lat_lane     <= req_addr[1:0];
                lat_wdata    <= req_wdata[15:0];
                lat_err      <= req_misaligned;
                mem_address  <= {req_addr[31:2], 2'b00};
                if (req_write && req_size[1] && !req_misaligned) begin
                    mem_data_input <= req_wdata;
                end
            end
            // Merged word is registered here so it is stable for the whole WR cycle
            // and still held through RESP.
            if (rd_done) begin
                rdata_q <= mem_data_out;
                if (lat_write) begin
                    mem_data_input <= merge_lane(mem_data_out, lat_size, lat_lane, lat_wdata);
                end
            end
        end
    end

    assign byte_sel = rdata_q[{lat_lane, 3'b000} +: 8];
    assign half_sel = rdata_q[{lat_lane[1], 4'b0000} +: 16];

    always_comb begin
        load_val = rdata_q;
        if (lat_size == 2'b00) begin
            load_val = {{24{byte_sel[7] & ~lat_unsigned}}, byte_sel};
        end else if (lat_size == 2'b01) begin
            load_val = {{16{half_sel[15] & ~lat_unsigned}}, half_sel};
        end
    end

    assign resp_err   = resp_valid && lat_err;
    assign resp_rdata = (resp_valid && !lat_write && !lat_err) ? load_val : 32'd0;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- CPU-side initiator for the word-wide data memory. It accepts one load/store request at a time from the MEM pipeline stage and drives the memory's address, write-data, MemRead and MemWrite signals.
- Implements byte and halfword loads (sign- or zero-extended) on the word-only memory. Implements byte and halfword stores by read-modify-write.
- Returns load data, or flags a misaligned access, through a valid/ready handshake. The pipeline stalls while req_ready is low.

Parameters:
- MEM_LATENCY, 1, number of cycles mem_read is held before mem_data_out is sampled; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit idle; request accepted when req_valid && req_ready
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle pulse: request complete
- resp_rdata  output  32  load result; 0 for stores and errors
- resp_err  output  1  misaligned access; qualified by resp_valid
- mem_address  output  32  word-aligned byte address to memory (bits [1:0] always 0)
- mem_data_input  output  32  write data to memory
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_data_out  input  32  read data from memory

Behaviour:
- Reset (async, reset_n low):
  - State goes to IDLE.
  - req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0.
  - mem_read=0; mem_write=0; mem_address=0; mem_data_input=0.
  - Latency counter and latched request fields are cleared.
- Reset mid-operation aborts the access with no response.
  - mem_write drops immediately (asynchronously).
  - A write already strobed in an earlier cycle is not undone.
- Byte-lane mapping is little-endian: lane = addr[1:0], bits [8*lane+7 : 8*lane]. Halfword lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Misaligned accesses:
  - A halfword with addr[0]=1, or a word with addr[1:0]!=0, is misaligned.
  - The unit goes IDLE->RESP with no memory strobe.
  - resp_err=1 and resp_rdata=0.
- States:
  - IDLE: req_ready=1. On acceptance, latch write/size/unsigned/addr/wdata and set mem_address={addr[31:2],2'b00}. Next state:
    - misaligned -> RESP
    - word store -> WR (mem_data_input=wdata)
    - any load or sub-word store -> RD (counter=MEM_LATENCY-1)
  - RD: mem_read=1. Counter decrements each cycle. When it reaches 0, capture mem_data_out into an internal word register at that clock edge. Next state: load -> RESP; sub-word store -> WR.
  - WR: mem_write=1 for exactly one cycle. mem_data_input = captured word with the addressed byte or halfword lane replaced by wdata[7:0] or wdata[15:0]; for a word store it is wdata. Next state: RESP.
  - RESP: resp_valid=1 for one cycle. Strobes are low. mem_address and mem_data_input are held unchanged so the level-sensitive memory sees no spurious write. Next state: IDLE.
- Load extraction:
  - Select the addressed lane from the captured word.
  - Byte: extend from bit 7. Halfword: extend from bit 15.
  - Sign- or zero-extend according to req_unsigned.
  - Word: pass through unchanged.
- req_ready is 0 in every state except IDLE. Inputs outside IDLE are ignored.
- A new request can be accepted in the cycle after the RESP cycle; there is no back-to-back acceptance in RESP.
- mem_read and mem_write are never asserted together.
- Latency from the acceptance edge to the resp_valid cycle:
  - word load: MEM_LATENCY+1
  - word store: 2
  - sub-word store: MEM_LATENCY+2
  - misaligned: 1

Test Plan:
- Memory word[8]=0x21101122, MEM_LATENCY=1: lbu addr 9 -> resp_rdata=0x00000011, resp_valid 2 cycles after accept; lb addr 11 -> 0x00000021.
- Memory word[0]=0xA01100AB: lh signed addr 2 -> 0xFFFFA011; lhu addr 2 -> 0x0000A011; lh signed addr 0 -> 0x000000AB.
- Memory word[12]=0x31000033: sb wdata=0x1234565A addr 13 -> one mem_write cycle with mem_address=12, mem_data_input=0x31005A33; a later lw addr 12 returns 0x31005A33.
- sw 0xDEADBEEF to addr 20 -> mem_read never asserted, mem_write for 1 cycle, resp_valid 2 cycles after accept; lw 20 returns 0xDEADBEEF.
- lw addr 6, and sh addr 5 -> no mem strobes, resp_valid next cycle, resp_err=1, resp_rdata=0; req_ready back to 1 the cycle after.
- MEM_LATENCY=3 sh at addr 18: pull reset_n low during RD -> outputs at reset values immediately, no mem_write, no resp_valid; next request completes normally.
